fixed_point_divider: RTL and testbench

- Sequential radix-2 restoring divider for the fixed-point datapath. Works on the same Q(WIDTH-FBITS).FBITS format as the fixed-point add/sub/mul/sqrt unit.
- Computes operand_1 / operand_2 and returns a fixed-point quotient in that format. This is the inverse of the fixed-point multiply.
- Sits beside the fixed-point unit and is started by the execute stage through a start/ready handshake.

---
 rtl/fixed_point_divider.sv | 171 +++++++++++++++++
 tb/tb_fixed_point_divider.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_divider.sv
// fixed_point_divider
//   Sequential radix-2 restoring divider for Q(WIDTH-FBITS).FBITS operands.
//   Computes operand_1 / operand_2 with the quotient truncated toward zero,
//   one quotient bit per clock, WIDTH+FBITS iterations per operation.
//
//   Optional feature: define FXDIV_SIGNED_EN for two's complement operands
//   (magnitudes are divided, the sign is applied afterwards, saturation is
//   to the signed limits). Without it the divider is purely unsigned.
//
//   Ports
//     clk          clock, rising edge
//     reset        asynchronous, active-high reset
//     start        request pulse, sampled only in IDLE
//     operand_1    dividend, fixed-point
//     operand_2    divisor, fixed-point
//     busy         high while dividing
//     result       quotient, held until the next completion
//     ready        one-cycle completion pulse
//     div_by_zero  divisor of the latched request was zero
//     overflow     quotient did not fit, result saturated
//
//   state  | meaning
//   IDLE   | waiting for start
//   DIVIDE | one quotient bit per cycle, ITER cycles
//   DONE   | outputs valid, ready pulse, back to IDLE next cycle
module fixed_point_divider #(
    parameter int WIDTH = 32,
    parameter int FBITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int N    = WIDTH + FBITS;
    localparam int ITER = N;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(ITER - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [N-1:0]     dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [N-1:0]     quot;

    logic [WIDTH+1:0] shift;
    logic [WIDTH+1:0] trial;
    logic             qbit;
    logic [WIDTH:0]   rem_next;
    logic [N-1:0]     quot_next;
    logic             quot_hi;
    logic [WIDTH-1:0] res_fin;
    logic             ovf_fin;
    logic [N-1:0]     dvd_load;
    logic [WIDTH-1:0] dvs_load;
    logic [WIDTH-1:0] dz_result;

`ifdef FXDIV_SIGNED_EN
    logic             neg_q;
    logic [WIDTH-1:0] op1_mag;
    logic [WIDTH-1:0] op2_mag;

    // magnitude of the most negative value is 2^(WIDTH-1), still fits unsigned
    assign op1_mag   = operand_1[WIDTH-1] ? (~operand_1 + 1'b1) : operand_1;
    assign op2_mag   = operand_2[WIDTH-1] ? (~operand_2 + 1'b1) : operand_2;
    assign dvd_load  = {op1_mag, {FBITS{1'b0}}};
    assign dvs_load  = op2_mag;
    assign dz_result = operand_1[WIDTH-1] ? MSB_ONLY : ~MSB_ONLY;
`else
    assign dvd_load  = {operand_1, {FBITS{1'b0}}};
    assign dvs_load  = operand_2;
    assign dz_result = '1;
`endif

    assign busy  = (state == DIVIDE);
    assign ready = (state == DONE);

    // One restoring step: the remainder is always below the divisor, so the
    // shifted value needs WIDTH+1 bits and one more bit carries the borrow.
    always_comb begin
        shift     = {rem, dvd[N-1]};
        trial     = shift - {2'b00, dvs};
        qbit      = ~trial[WIDTH+1];
        rem_next  = qbit ? trial[WIDTH:0] : shift[WIDTH:0];
        quot_next = (quot << 1) | {{(N-1){1'b0}}, qbit};
    end

    always_comb begin
        quot_hi = |quot_next[N-1:WIDTH];
`ifdef FXDIV_SIGNED_EN
        if (neg_q) begin
            ovf_fin = quot_hi | (quot_next[WIDTH-1:0] > MSB_ONLY);
            res_fin = ovf_fin ? MSB_ONLY : (~quot_next[WIDTH-1:0] + 1'b1);
        end else begin
            ovf_fin = quot_hi | quot_next[WIDTH-1];
            res_fin = ovf_fin ? ~MSB_ONLY : quot_next[WIDTH-1:0];
        end
`else
        ovf_fin = quot_hi;
        res_fin = quot_hi ? '1 : quot_next[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            quot        <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
`ifdef FXDIV_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        overflow <= 1'b0;
                        if (operand_2 == '0) begin
                            result      <= dz_result;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            dvd         <= dvd_load;
                            dvs         <= dvs_load;
                            rem         <= '0;
                            quot        <= '0;
                            cnt         <= CNT_LOAD;
`ifdef FXDIV_SIGNED_EN
                            neg_q       <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
`endif
                            state       <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem  <= rem_next;
                    quot <= quot_next;
                    dvd  <= dvd << 1;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result   <= res_fin;
                        overflow <= ovf_fin;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divider.sv
module tb_fixed_point_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        busy;
    logic [31:0] result;
    logic        ready;
    logic        div_by_zero;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int lat;
    int bcnt;

`ifdef FXDIV_SIGNED_EN
    localparam logic [31:0] DZ_RES  = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_RES = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] DZ_RES  = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_RES = 32'hFFFF_FFFF;
`endif

    fixed_point_divider #(.WIDTH(32), .FBITS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .busy       (busy),
        .result     (result),
        .ready      (ready),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        operand_1 = a;
        operand_2 = b;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // n counts negedges after the accept edge, starting at 0; a poke drives a
    // one-cycle start with a zero divisor at negedge n == poke
    task automatic wait_ready(input int poke, output int latency, output int busy_cycles);
        int n = 0;
        bit found = 1'b0;
        busy_cycles = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            if (poke >= 0 && n == poke) begin
                start     = 1'b1;
                operand_1 = 32'h400;
                operand_2 = 32'h0;
            end else if (poke >= 0 && n == poke + 1) begin
                start = 1'b0;
            end
            if (ready) found = 1'b1;
            else begin
                if (busy) busy_cycles++;
                n++;
            end
        end
        check("ready_seen", {31'd0, found}, 32'd1);
        latency = n;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        operand_1 = '0;
        operand_2 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy},        32'd0);
        check("rst_ready", {31'd0, ready},       32'd0);
        check("rst_result", result,              32'd0);
        check("rst_dz",    {31'd0, div_by_zero}, 32'd0);
        check("rst_ovf",   {31'd0, overflow},    32'd0);
        reset = 1'b0;

        // 6.0 / 2.0
        launch(32'h1800, 32'h800);
        wait_ready(-1, lat, bcnt);
        check("six_lat",    lat,  32'd42);
        check("six_busy",   bcnt, 32'd42);
        check("six_result", result, 32'hC00);
        check("six_dz",     {31'd0, div_by_zero}, 32'd0);
        check("six_ovf",    {31'd0, overflow},    32'd0);
        repeat (3) @(negedge clk);
        check("hold_ready",  {31'd0, ready}, 32'd0);
        check("hold_result", result, 32'hC00);

        // 1.0 / 3.0
        launch(32'h400, 32'hC00);
        wait_ready(-1, lat, bcnt);
        check("third_lat",    lat, 32'd42);
        check("third_result", result, 32'h155);
        check("third_ovf",    {31'd0, overflow}, 32'd0);

        // divide by zero
        launch(32'h400, 32'h0);
        wait_ready(-1, lat, bcnt);
        check("dz_lat",    lat,  32'd0);
        check("dz_busy",   bcnt, 32'd0);
        check("dz_result", result, DZ_RES);
        check("dz_flag",   {31'd0, div_by_zero}, 32'd1);
        check("dz_ovf",    {31'd0, overflow},    32'd0);

        // overflow
        launch(32'h7FFF_FFFF, 32'h1);
        wait_ready(-1, lat, bcnt);
        check("ovf_result", result, OVF_RES);
        check("ovf_flag",   {31'd0, overflow},    32'd1);
        check("ovf_dz",     {31'd0, div_by_zero}, 32'd0);

        // start and operand changes during DIVIDE are ignored
        launch(32'h1800, 32'h800);
        wait_ready(10, lat, bcnt);
        check("poke_lat",    lat, 32'd42);
        check("poke_result", result, 32'hC00);
        check("poke_dz",     {31'd0, div_by_zero}, 32'd0);
        check("poke_ovf",    {31'd0, overflow},    32'd0);

        // reset mid-operation
        launch(32'h1800, 32'h800);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy",   {31'd0, busy},  32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_ready",  {31'd0, ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        launch(32'h1800, 32'h800);
        wait_ready(-1, lat, bcnt);
        check("after_rst_lat",    lat, 32'd42);
        check("after_rst_result", result, 32'hC00);

        // start held high: re-accepted on the first IDLE cycle after DONE
        @(negedge clk);
        operand_1 = 32'h400;
        operand_2 = 32'hC00;
        start     = 1'b1;
        @(posedge clk);
        #1;
        wait_ready(-1, lat, bcnt);
        check("held_lat",    lat, 32'd42);
        check("held_result", result, 32'h155);
        @(negedge clk);
        check("held_idle_busy",  {31'd0, busy},  32'd0);
        check("held_idle_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        check("held_reaccept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_ready(-1, lat, bcnt);
        check("held2_lat",    lat, 32'd41);
        check("held2_result", result, 32'h155);

`ifdef FXDIV_SIGNED_EN
        launch(32'hFFFF_E800, 32'h800);
        wait_ready(-1, lat, bcnt);
        check("sgn_neg_result", result, 32'hFFFF_F400);
        check("sgn_neg_ovf",    {31'd0, overflow}, 32'd0);

        launch(32'h8000_0000, 32'h1);
        wait_ready(-1, lat, bcnt);
        check("sgn_min_result", result, 32'h8000_0000);
        check("sgn_min_ovf",    {31'd0, overflow}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
